// File: rtl/mips_multicycle_controller.sv
// Moore-style control FSM for the multi-cycle MIPS datapath: decodes IR opcode/funct
// and drives every datapath load, select and ALU-opcode signal each cycle.
module mips_multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_ld_en,
  output logic [1:0] pc_next_sel,
  output logic       i_or_d,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic       ir_ld_en,
  output logic       reg_wr_en,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] reg_data_sel,
  output logic       alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [2:0] alu_opc,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_LW_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_I_EXEC = 4'd9, S_I_WB = 4'd10, S_JUMP = 4'd11,
    S_JAL = 4'd12, S_JR = 4'd13, S_HALT = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t     state, next_state;
  logic       r_legal;
  logic [2:0] r_opc;
  logic       unsupported;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  assign state_o = state;

  always_comb begin
    r_legal = 1'b1;
    r_opc   = 3'b000;
    case (funct)
      6'b100000: r_opc = 3'b000;
      6'b100010: r_opc = 3'b001;
      6'b100100: r_opc = 3'b010;
      6'b100101: r_opc = 3'b011;
      6'b101010: r_opc = 3'b100;
      default:   r_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state   = state;
    unsupported  = 1'b0;
    pc_ld_en     = 1'b0;
    pc_next_sel  = 2'b00;
    i_or_d       = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    ir_ld_en     = 1'b0;
    reg_wr_en    = 1'b0;
    reg_dst_sel  = 2'b00;
    reg_data_sel = 2'b00;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 2'b00;
    alu_opc      = 3'b000;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd_en  = 1'b1;
        ir_ld_en   = 1'b1;
        alu_b_sel  = 2'b01;
        pc_ld_en   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // branch target computed speculatively into ALUout
        alu_b_sel = 2'b11;
        case (opcode)
          OP_RTYPE: begin
            if (r_legal)              next_state = S_R_EXEC;
            else if (funct == FN_JR)  next_state = S_JR;
            else                      unsupported = 1'b1;
          end
          OP_LW, OP_SW:     next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   next_state = S_BRANCH;
          OP_ADDI, OP_SLTI: next_state = S_I_EXEC;
          OP_J:             next_state = S_JUMP;
          OP_JAL:           next_state = S_JAL;
          default:          unsupported = 1'b1;
        endcase
        if (unsupported) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_a_sel  = 1'b1;
        alu_b_sel  = 2'b10;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd_en  = 1'b1;
        i_or_d     = 1'b1;
        next_state = S_LW_WB;
      end
      S_LW_WB: begin
        reg_wr_en    = 1'b1;
        reg_data_sel = 2'b01;
        instr_done   = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr_en  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_R_EXEC: begin
        alu_a_sel  = 1'b1;
        alu_opc    = r_opc;
        next_state = S_R_WB;
      end
      S_R_WB: begin
        alu_a_sel   = 1'b1;
        alu_opc     = r_opc;
        reg_wr_en   = 1'b1;
        reg_dst_sel = 2'b01;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        alu_a_sel   = 1'b1;
        alu_opc     = 3'b001;
        pc_next_sel = 2'b01;
        pc_ld_en    = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_I_EXEC: begin
        alu_a_sel  = 1'b1;
        alu_b_sel  = 2'b10;
        alu_opc    = (opcode == OP_SLTI) ? 3'b100 : 3'b000;
        next_state = S_I_WB;
      end
      S_I_WB: begin
        reg_wr_en  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_next_sel = 2'b10;
        pc_ld_en    = 1'b1;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        reg_wr_en    = 1'b1;
        reg_dst_sel  = 2'b10;
        reg_data_sel = 2'b10;
        pc_next_sel  = 2'b10;
        pc_ld_en     = 1'b1;
        instr_done   = 1'b1;
        next_state   = S_FETCH;
      end
      S_JR: begin
        pc_next_sel = 2'b11;
        pc_ld_en    = 1'b1;
        instr_done  = 1'b1;
        next_state  = S_FETCH;
      end
      S_HALT: illegal = 1'b1;
      default: next_state = S_FETCH;
    endcase
    // reset forces every output quiet, including the FETCH outputs of the reset state
    if (rst) begin
      pc_ld_en     = 1'b0;
      pc_next_sel  = 2'b00;
      i_or_d       = 1'b0;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      ir_ld_en     = 1'b0;
      reg_wr_en    = 1'b0;
      reg_dst_sel  = 2'b00;
      reg_data_sel = 2'b00;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 2'b00;
      alu_opc      = 3'b000;
      instr_done   = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: instruction-level reference model feeding an
// expected queue, a negedge compare process, and directed reset/HALT sequences.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst, rst_h, zero;
  logic [5:0] opcode, funct, opcode_h;

  logic       pc_ld_en, i_or_d, mem_rd_en, mem_wr_en, ir_ld_en, reg_wr_en, alu_a_sel, instr_done, illegal;
  logic [1:0] pc_next_sel, reg_dst_sel, reg_data_sel, alu_b_sel;
  logic [2:0] alu_opc;
  logic [3:0] state_o;

  logic       pc_ld_en_h, i_or_d_h, mem_rd_en_h, mem_wr_en_h, ir_ld_en_h, reg_wr_en_h, alu_a_sel_h, instr_done_h, illegal_h;
  logic [1:0] pc_next_sel_h, reg_dst_sel_h, reg_data_sel_h, alu_b_sel_h;
  logic [2:0] alu_opc_h;
  logic [3:0] state_o_h;

  typedef struct packed {
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic       iord, mrd, mwr, irld, rwr;
    logic [1:0] rdst, rdata;
    logic       asel;
    logic [1:0] bsel;
    logic [2:0] opc;
    logic       done, ill;
    logic [3:0] st;
  } outs_t;

  localparam int W = 24;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act, act_h;
  int checks = 0;
  int errors = 0;

  assign act = {pc_ld_en, pc_next_sel, i_or_d, mem_rd_en, mem_wr_en, ir_ld_en, reg_wr_en,
                reg_dst_sel, reg_data_sel, alu_a_sel, alu_b_sel, alu_opc, instr_done, illegal, state_o};
  assign act_h = {pc_ld_en_h, pc_next_sel_h, i_or_d_h, mem_rd_en_h, mem_wr_en_h, ir_ld_en_h, reg_wr_en_h,
                  reg_dst_sel_h, reg_data_sel_h, alu_a_sel_h, alu_b_sel_h, alu_opc_h, instr_done_h, illegal_h, state_o_h};

  mips_multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_ld_en(pc_ld_en), .pc_next_sel(pc_next_sel), .i_or_d(i_or_d), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .ir_ld_en(ir_ld_en), .reg_wr_en(reg_wr_en), .reg_dst_sel(reg_dst_sel),
    .reg_data_sel(reg_data_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_opc(alu_opc),
    .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  mips_multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .rst(rst_h), .opcode(opcode_h), .funct(funct), .zero(zero),
    .pc_ld_en(pc_ld_en_h), .pc_next_sel(pc_next_sel_h), .i_or_d(i_or_d_h), .mem_rd_en(mem_rd_en_h),
    .mem_wr_en(mem_wr_en_h), .ir_ld_en(ir_ld_en_h), .reg_wr_en(reg_wr_en_h), .reg_dst_sel(reg_dst_sel_h),
    .reg_data_sel(reg_data_sel_h), .alu_a_sel(alu_a_sel_h), .alu_b_sel(alu_b_sel_h), .alu_opc(alu_opc_h),
    .instr_done(instr_done_h), .illegal(illegal_h), .state_o(state_o_h)
  );

  // clock / reset block
  always #5 clk = ~clk;

  localparam logic [W-1:0] FETCH_V = {1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 4'd0};

  task automatic chk(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h req=%h t=%0t", name, a, e, $time);
    end
  endtask

  // instruction-level model: every cycle of one instruction, from FETCH to its last cycle
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    outs_t o;
    string kind;
    logic [2:0] ropc;
    ropc = 3'b000;
    case (fn)
      6'b100000: begin kind = "r"; ropc = 3'b000; end
      6'b100010: begin kind = "r"; ropc = 3'b001; end
      6'b100100: begin kind = "r"; ropc = 3'b010; end
      6'b100101: begin kind = "r"; ropc = 3'b011; end
      6'b101010: begin kind = "r"; ropc = 3'b100; end
      6'b001000: kind = "jr";
      default:   kind = "bad";
    endcase
    case (op)
      6'b000000: ;
      6'b100011: kind = "lw";
      6'b101011: kind = "sw";
      6'b000100: kind = "beq";
      6'b000101: kind = "bne";
      6'b001000: kind = "addi";
      6'b001010: kind = "slti";
      6'b000010: kind = "j";
      6'b000011: kind = "jal";
      default:   kind = "bad";
    endcase
    exp_q.push_back(FETCH_V);
    o = '0; o.bsel = 2'b11; o.st = 4'd1;
    if (kind == "bad") begin o.done = 1'b1; o.ill = 1'b1; end
    exp_q.push_back(o);
    if (kind == "lw" || kind == "sw") begin
      o = '0; o.asel = 1'b1; o.bsel = 2'b10; o.st = 4'd2; exp_q.push_back(o);
    end
    if (kind == "lw") begin
      o = '0; o.iord = 1'b1; o.mrd = 1'b1; o.st = 4'd3; exp_q.push_back(o);
      o = '0; o.rwr = 1'b1; o.rdata = 2'b01; o.done = 1'b1; o.st = 4'd4; exp_q.push_back(o);
    end
    if (kind == "sw") begin
      o = '0; o.iord = 1'b1; o.mwr = 1'b1; o.done = 1'b1; o.st = 4'd5; exp_q.push_back(o);
    end
    if (kind == "r") begin
      o = '0; o.asel = 1'b1; o.opc = ropc; o.st = 4'd6; exp_q.push_back(o);
      o.rwr = 1'b1; o.rdst = 2'b01; o.done = 1'b1; o.st = 4'd7; exp_q.push_back(o);
    end
    if (kind == "beq" || kind == "bne") begin
      o = '0; o.pc_ld = (kind == "beq") ? z : !z; o.pc_sel = 2'b01; o.asel = 1'b1;
      o.opc = 3'b001; o.done = 1'b1; o.st = 4'd8; exp_q.push_back(o);
    end
    if (kind == "addi" || kind == "slti") begin
      o = '0; o.asel = 1'b1; o.bsel = 2'b10; o.opc = (kind == "slti") ? 3'b100 : 3'b000;
      o.st = 4'd9; exp_q.push_back(o);
      o = '0; o.rwr = 1'b1; o.done = 1'b1; o.st = 4'd10; exp_q.push_back(o);
    end
    if (kind == "j" || kind == "jal" || kind == "jr") begin
      o = '0; o.pc_ld = 1'b1; o.done = 1'b1;
      o.pc_sel = (kind == "jr") ? 2'b11 : 2'b10;
      o.st = (kind == "j") ? 4'd11 : (kind == "jal") ? 4'd12 : 4'd13;
      if (kind == "jal") begin o.rwr = 1'b1; o.rdst = 2'b10; o.rdata = 2'b10; end
      exp_q.push_back(o);
    end
  endtask

  // driver: called just after a rising edge with the DUT in FETCH
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n);
    opcode = op; funct = fn; zero = z;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n0;
    n0 = exp_q.size();
    model_instr(op, fn, z);
    drive(op, fn, z, exp_q.size() - n0);
  endtask

  // scoreboard compare process
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_outputs op=%b fn=%b act=%h req=%h t=%0t", opcode, funct, act, e, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [5:0] op, fn;
    int sel;
    rst = 1'b1; rst_h = 1'b1; zero = 1'b0;
    opcode = '0; funct = '0; opcode_h = '0;
    @(negedge clk);
    chk("reset_quiet", act, '0);
    @(posedge clk); #1 rst = 1'b0;

    // model pins against hand-derived vectors
    model_instr(6'b100011, 6'd0, 1'b0);
    chk("lw_len", W'(exp_q.size()), W'(5));
    chk("lw_wb", exp_q[4], {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 4'd4});
    drive(6'b100011, 6'd0, 1'b0, exp_q.size());

    model_instr(6'b000000, 6'b100010, 1'b0);
    chk("sub_len", W'(exp_q.size()), W'(4));
    chk("sub_exec", exp_q[2], {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 4'd6});
    chk("sub_wb", exp_q[3], {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 2'b00, 3'b001, 1'b1, 1'b0, 4'd7});
    drive(6'b000000, 6'b100010, 1'b0, exp_q.size());

    run_instr(6'b000000, 6'b101010, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);

    model_instr(6'b000101, 6'd0, 1'b1);
    chk("bne_taken_zero", exp_q[2], {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 3'b001, 1'b1, 1'b0, 4'd8});
    drive(6'b000101, 6'd0, 1'b1, exp_q.size());
    run_instr(6'b000101, 6'd0, 1'b0);

    model_instr(6'b000011, 6'd0, 1'b0);
    chk("jal_len", W'(exp_q.size()), W'(3));
    chk("jal", exp_q[2], {1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 4'd12});
    drive(6'b000011, 6'd0, 1'b0, exp_q.size());
    run_instr(6'b000000, 6'b001000, 1'b0);

    model_instr(6'b111111, 6'd0, 1'b0);
    chk("illegal_len", W'(exp_q.size()), W'(2));
    chk("illegal_decode", exp_q[1], {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000, 1'b1, 1'b1, 4'd1});
    drive(6'b111111, 6'd0, 1'b0, exp_q.size());
    run_instr(6'b101011, 6'd0, 1'b1);

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 11);
      fn = 6'($urandom_range(0, 63));
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = 6'b100000 | 6'($urandom_range(0, 1) * 2); end
        3: begin op = 6'b000000; fn = ($urandom_range(0, 1) != 0) ? 6'b100100 : 6'b100101; end
        4: begin op = 6'b000000; fn = 6'b101010; end
        5: begin op = 6'b000000; fn = 6'b001000; end
        6: op = ($urandom_range(0, 1) != 0) ? 6'b000100 : 6'b000101;
        7: op = ($urandom_range(0, 1) != 0) ? 6'b001000 : 6'b001010;
        8: op = ($urandom_range(0, 1) != 0) ? 6'b000010 : 6'b000011;
        9: op = 6'b000000;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a lw, while in MEM_RD
    opcode = 6'b100011; funct = 6'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_state", {20'd0, state_o}, W'(3));
    rst = 1'b1;
    #1;
    chk("reset_async", act, '0);
    @(negedge clk);
    chk("reset_hold", act, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_reset_fetch", act, FETCH_V);
    run_instr(6'b000010, 6'd0, 1'b0);

    // HALT_ON_ILLEGAL=1 instance parks until reset
    rst_h = 1'b0; opcode_h = 6'b111111;
    @(negedge clk);
    chk("halt_fetch", act_h, FETCH_V);
    @(negedge clk);
    chk("halt_decode", act_h, {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000, 1'b1, 1'b1, 4'd1});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("halt_park", act_h, {20'd1, 4'd14});
    end
    rst_h = 1'b1;
    #1;
    chk("halt_reset", act_h, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Moore-style FSM controller that sequences a shared-memory, single-ALU multi-cycle MIPS datapath, the successor to the single-cycle core.
- Decodes opcode and funct from the datapath instruction register.
- Drives every datapath load, select and ALU-opcode signal each cycle, and takes `zero` back from the ALU.
- Pairs 1:1 with the multi-cycle datapath inside the top-level MIPS wrapper.

Parameters:
- HALT_ON_ILLEGAL, 0, if 1 an unsupported instruction parks the FSM in HALT until reset; if 0 it is skipped (treated as NOP).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from datapath
- pc_ld_en  out  1  PC load
- pc_next_sel  out  2  00 ALU result, 01 ALUout (branch target), 10 jump target {PC[31:28],IR[25:0],00}, 11 rs
- i_or_d  out  1  memory address: 0 PC, 1 ALUout
- mem_rd_en  out  1  memory read
- mem_wr_en  out  1  memory write
- ir_ld_en  out  1  IR load
- reg_wr_en  out  1  register file write
- reg_dst_sel  out  2  00 rt, 01 rd, 10 $31
- reg_data_sel  out  2  00 ALUout, 01 MDR, 10 PC
- alu_a_sel  out  1  0 PC, 1 A reg
- alu_b_sel  out  2  00 B reg, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
- alu_opc  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- instr_done  out  1  high in the last cycle of each instruction
- illegal  out  1  high in DECODE when opcode/funct unsupported; stays high in HALT
- state_o  out  4  current state encoding

Behaviour:
- Reset:
  - State forced to FETCH (0) asynchronously.
  - While rst=1 all enables (pc_ld_en, mem_rd_en, mem_wr_en, ir_ld_en, reg_wr_en), instr_done and illegal are 0.
  - All select outputs and alu_opc are 0.
  - Reset asserted mid-instruction aborts it; no write is issued in the reset cycle.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, LW_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, I_EXEC 9, I_WB 10, JUMP 11, JAL 12, JR 13, HALT 14.
- Outputs depend on state only. Exception: pc_ld_en in BRANCH is the registered state AND'd with the live `zero` condition.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_rd_en, i_or_d=0, ir_ld_en, alu_a=PC, alu_b=01, add, pc_next_sel=00, pc_ld_en.
  - Next state: DECODE.
- DECODE:
  - Outputs: alu_a=PC, alu_b=11, add (branch target latched into ALUout).
  - Transitions by opcode:
    - 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> R_EXEC
    - 000000 with funct 001000 -> JR
    - 100011, 101011 -> MEM_ADDR
    - 000100, 000101 -> BRANCH
    - 001000, 001010 -> I_EXEC
    - 000010 -> JUMP
    - 000011 -> JAL
    - anything else: illegal=1, instr_done=1, next state HALT if HALT_ON_ILLEGAL else FETCH.
- MEM_ADDR: alu_a=A, alu_b=10, add. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_rd_en, i_or_d=1. Next state LW_WB.
- LW_WB: reg_wr_en, reg_dst=00, reg_data=01, instr_done. Next state FETCH.
- MEM_WR: mem_wr_en, i_or_d=1, instr_done. Next state FETCH.
- R_EXEC:
  - alu_a=A, alu_b=00.
  - alu_opc from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Next state R_WB.
- R_WB: reg_wr_en, reg_dst=01, reg_data=00, instr_done. Alu inputs and opc held. Next state FETCH.
- BRANCH:
  - alu_a=A, alu_b=00, sub, pc_next_sel=01.
  - pc_ld_en = zero for beq, ~zero for bne.
  - instr_done. Next state FETCH.
- I_EXEC: alu_a=A, alu_b=10, alu_opc add (addi) or slt (slti). Next state I_WB.
- I_WB: reg_wr_en, reg_dst=00, reg_data=00, instr_done. Next state FETCH.
- JUMP: pc_next_sel=10, pc_ld_en, instr_done. Next state FETCH.
- JAL:
  - Outputs: reg_wr_en, reg_dst=10, reg_data=10 (PC already holds PC+4), pc_next_sel=10, pc_ld_en, instr_done.
  - Next state: FETCH.
- JR: pc_next_sel=11, pc_ld_en, instr_done. Next state FETCH.
- HALT: all enables 0, illegal=1. Leaves only on reset.
- Latency in cycles, FETCH through last state:
  - lw 5
  - sw, R-type, addi, slti 4
  - beq, bne, j, jal, jr 3
  - illegal 2
- instr_done is exactly one cycle per instruction.
- opcode and funct must be held stable by the IR from DECODE onward. The controller does not latch them.

Test Plan:
- Reset mid-MEM_RD -> state_o=0 immediately (async); all enables 0 while rst=1; first clk after release shows FETCH outputs (mem_rd_en=1, ir_ld_en=1, pc_ld_en=1, alu_b_sel=01).
- lw (100011) -> state sequence 0,1,2,3,4,0; in state 4 reg_wr_en=1, reg_dst_sel=00, reg_data_sel=01; instr_done asserted once.
- R-type sub (funct 100010) -> states 0,1,6,7; alu_opc=001 in 6 and 7; reg_dst_sel=01 in 7; same sequence with funct 101010 gives alu_opc=100.
- beq with zero=1 -> pc_ld_en=1 and pc_next_sel=01 in BRANCH; beq with zero=0 -> pc_ld_en=0; bne inverts both cases.
- jal (000011) -> states 0,1,12; in 12 reg_dst_sel=10, reg_data_sel=10, pc_next_sel=10, reg_wr_en=1, pc_ld_en=1. jr (funct 001000) -> pc_next_sel=11.
- opcode 111111 -> illegal=1 in DECODE; with HALT_ON_ILLEGAL=0 returns to FETCH; with HALT_ON_ILLEGAL=1 state_o=14 held for 20 cycles with all enables 0 until rst.
